// File: rtl/chan_rd_pkg.sv
// chan_rd_pkg: shared types for the channel FIFO reader
package chan_rd_pkg;
   localparam int C_WORD_W = 16;
   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, WAIT_EOP} t_ChanRdState;
   typedef struct packed {
      logic [C_WORD_W-1:0] data;
      logic                sop;
      logic                eop;
   } t_StreamWord;
endpackage

// File: rtl/chan_rd_skid.sv
// chan_rd_skid: two-entry word buffer absorbing the one-cycle channel FIFO read latency
module chan_rd_skid
   import chan_rd_pkg::*;
(
   input  logic        clk,
   input  logic        i_Reset,
   input  logic        i_Push,
   input  t_StreamWord i_Word,
   input  logic        i_Pop,
   output t_StreamWord o_Head,
   output logic        o_Valid,
   output logic [1:0]  o_Occupancy
);
   t_StreamWord mem [2];
   logic        wrPtr, rdPtr, doPop;
   assign o_Valid = o_Occupancy != 2'd0;
   assign doPop   = i_Pop & o_Valid;
   assign o_Head  = mem[rdPtr];
   always_ff @(posedge clk) begin
      if (i_Reset) begin
         mem         <= '{default: '0};
         wrPtr       <= 1'b0;
         rdPtr       <= 1'b0;
         o_Occupancy <= 2'd0;
      end else begin
         if (i_Push) begin
            mem[wrPtr] <= i_Word;
            wrPtr      <= !wrPtr;
         end
         if (doPop) rdPtr <= !rdPtr;
         o_Occupancy <= o_Occupancy + 2'(i_Push) - 2'(doPop);
      end
   end
endmodule

// File: rtl/channel_fifo_reader.sv
// channel_fifo_reader: drains fixed-length channel events and re-emits them as a framed valid/ready stream
module channel_fifo_reader
   import chan_rd_pkg::*;
#(
   parameter int g_ChannelId  = 15,
   parameter int g_EventWords = 16
) (
   input  logic                clk,
   input  logic                i_Reset,
   input  logic                i_MasterEnable,
   input  logic                i_FifoEmpty,
   input  logic [C_WORD_W-1:0] i_FifoData,
   output logic                o_FifoRead,
   output logic [C_WORD_W-1:0] o_Data,
   output logic                o_Valid,
   input  logic                i_Ready,
   output logic                o_Sop,
   output logic                o_Eop,
   output logic                o_HeaderError,
   output logic [15:0]         o_EventCount,
   output logic                o_Busy
);
   localparam logic [7:0] C_ID   = 8'(g_ChannelId);
   localparam logic [7:0] C_LAST = 8'(g_EventWords - 1);
   t_ChanRdState state, nextState;
   t_StreamWord  head, pushWord;
   logic [7:0]   wordCnt;
   logic [1:0]   occ;
   logic         inFlight, push, pop, match, fetchLeft;
   assign pop    = o_Valid & i_Ready;
   assign match  = i_FifoData[7:0] == C_ID;
   assign o_Data = head.data;
   assign o_Sop  = head.sop;
   assign o_Eop  = head.eop;
   assign o_Busy = state != IDLE;
   // Occupancy after this cycle's pop plus the word returning now must leave room for the new read
   assign o_FifoRead = !i_Reset && !i_FifoEmpty && fetchLeft &&
                       ((3'(occ) + 3'(inFlight) - 3'(pop)) < 3'd2);
   always_comb begin
      nextState = state;
      push      = 1'b0;
      fetchLeft = 1'b0;
      pushWord  = '{data: i_FifoData, sop: 1'b0, eop: 1'b0};
      case (state)
         IDLE: if (i_MasterEnable && !i_FifoEmpty) nextState = HEADER;
         HEADER: begin
            fetchLeft = 1'b1;
            if (inFlight && match) begin
               push         = 1'b1;
               pushWord.sop = 1'b1;
               nextState    = PAYLOAD;
            end else if (!inFlight && i_FifoEmpty) nextState = IDLE;
         end
         PAYLOAD: begin
            fetchLeft = (9'(wordCnt) + 9'(inFlight)) < 9'(g_EventWords);
            if (inFlight) begin
               push         = 1'b1;
               pushWord.eop = wordCnt == C_LAST;
               if (wordCnt == C_LAST) nextState = WAIT_EOP;
            end
         end
         WAIT_EOP: if (pop && head.eop) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (i_Reset) begin
         state         <= IDLE;
         inFlight      <= 1'b0;
         wordCnt       <= 8'd0;
         o_HeaderError <= 1'b0;
         o_EventCount  <= 16'd0;
      end else begin
         state         <= nextState;
         inFlight      <= o_FifoRead;
         wordCnt       <= (state == HEADER) ? 8'd1 : wordCnt + 8'(push);
         o_HeaderError <= state == HEADER && inFlight && !match;
         o_EventCount  <= o_EventCount + 16'(pop && head.eop);
      end
   end
   chan_rd_skid u_skid (
      .clk         (clk),
      .i_Reset     (i_Reset),
      .i_Push      (push),
      .i_Word      (pushWord),
      .i_Pop       (pop),
      .o_Head      (head),
      .o_Valid     (o_Valid),
      .o_Occupancy (occ)
   );
endmodule
